tick_event_scheduler: RTL and testbench

//   Generates periodic events on NCH independent channels, each with its own programmable period in clk cycles.

---
 rtl/tick_event_scheduler_if.sv | 23 ++
 rtl/tick_event_scheduler.sv | 154 +++++++++++++++
 tb/tb_tick_event_scheduler.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/tick_event_scheduler_if.sv
// Event port of the tick scheduler: one expired channel presented per valid/ready handshake.
interface tick_event_scheduler_if #(
  parameter int unsigned NCH = 4
);
  logic                   evt_valid;
  logic                   evt_ready;
  logic [$clog2(NCH)-1:0] evt_ch;
  logic                   evt_overrun;

  modport master (
    output evt_valid,
    output evt_ch,
    output evt_overrun,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_ch,
    input  evt_overrun,
    output evt_ready
  );
endinterface

// File: rtl/tick_event_scheduler.sv
// Per-channel programmable period counters whose expiries are shared onto one
// valid/ready event port by a round-robin arbiter.
module tick_event_scheduler #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_we,
  input  logic [$clog2(NCH)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]       cfg_period,
  input  logic [NCH-1:0]         ch_en,
  tick_event_scheduler_if.master evt,
  output logic [NCH-1:0]         pending
);

  localparam int unsigned CH_W = $clog2(NCH);

  typedef enum logic {StIdle, StPresent} state_e;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   rr_q, rr_d;
  logic [CH_W-1:0]   evt_ch_q, evt_ch_d;
  logic              evt_ovr_q, evt_ovr_d;
  logic [CNT_W-1:0]  period_q [NCH];
  logic [CNT_W-1:0]  period_d [NCH];
  logic [CNT_W-1:0]  cnt_q [NCH];
  logic [CNT_W-1:0]  cnt_d [NCH];
  logic [NCH-1:0]    pending_q, pending_d;
  logic [NCH-1:0]    ovr_q, ovr_d;
  logic [NCH-1:0]    wrap;

  logic              gnt_found;
  logic [CH_W-1:0]   gnt_idx;
  logic              gnt_fire;
  int unsigned       scan_sum;

  // First pending channel at or after the round-robin pointer, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_sum  = 0;
    for (int j = 0; j < NCH; j++) begin
      scan_sum = (int'(rr_q) + j) % NCH;
      if (!gnt_found && pending_q[CH_W'(scan_sum)]) begin
        gnt_found = 1'b1;
        gnt_idx   = CH_W'(scan_sum);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    evt_ch_d  = evt_ch_q;
    evt_ovr_d = evt_ovr_q;
    gnt_fire  = 1'b0;

    unique case (state_q)
      StIdle: begin
        gnt_fire = gnt_found;
      end
      StPresent: begin
        if (evt.evt_ready) begin
          if (gnt_found) begin
            gnt_fire = 1'b1;
          end else begin
            state_d   = StIdle;
            evt_ch_d  = '0;
            evt_ovr_d = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (gnt_fire) begin
      state_d   = StPresent;
      evt_ch_d  = gnt_idx;
      evt_ovr_d = ovr_q[gnt_idx];
      rr_d      = (gnt_idx == CH_W'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Counter, pending and overrun update; a config write overrides a same-cycle wrap.
  always_comb begin
    pending_d = pending_q;
    ovr_d     = ovr_q;
    wrap      = '0;
    for (int i = 0; i < NCH; i++) begin
      logic cfg_hit;
      logic run;
      logic granted;
      cfg_hit     = cfg_we && (cfg_ch == CH_W'(i));
      run         = ch_en[i] && (period_q[i] != '0);
      granted     = gnt_fire && (gnt_idx == CH_W'(i));
      wrap[i]     = run && (cnt_q[i] == period_q[i] - 1'b1) && !cfg_hit;
      period_d[i] = cfg_hit ? cfg_period : period_q[i];

      if (cfg_hit || !run || wrap[i]) begin
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end

      if (granted) begin
        pending_d[i] = 1'b0;
        ovr_d[i]     = 1'b0;
      end
      if (wrap[i]) begin
        if (pending_q[i] && !granted) begin
          ovr_d[i] = 1'b1;
        end
        pending_d[i] = 1'b1;
      end
      if (cfg_hit) begin
        pending_d[i] = 1'b0;
        ovr_d[i]     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      rr_q      <= '0;
      evt_ch_q  <= '0;
      evt_ovr_q <= 1'b0;
      pending_q <= '0;
      ovr_q     <= '0;
      for (int i = 0; i < NCH; i++) begin
        period_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      evt_ch_q  <= evt_ch_d;
      evt_ovr_q <= evt_ovr_d;
      pending_q <= pending_d;
      ovr_q     <= ovr_d;
      for (int i = 0; i < NCH; i++) begin
        period_q[i] <= period_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
    end
  end

  assign evt.evt_valid   = (state_q == StPresent);
  assign evt.evt_ch      = evt_ch_q;
  assign evt.evt_overrun = evt_ovr_q;
  assign pending         = pending_q;

endmodule

// File: tb/tb_tick_event_scheduler.sv
// Directed bench for tick_event_scheduler: hand-timed expiry, arbitration,
// overrun, config-collision and reset scenarios.
module tb_tick_event_scheduler;

  localparam int unsigned NCH   = 4;
  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             cfg_we;
  logic [1:0]       cfg_ch;
  logic [CNT_W-1:0] cfg_period;
  logic [NCH-1:0]   ch_en;
  logic [NCH-1:0]   pending;

  int n_checks;
  int n_fail;
  logic seen;

  tick_event_scheduler_if #(.NCH(NCH)) evt_if ();

  tick_event_scheduler #(
    .NCH   (NCH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .ch_en      (ch_en),
    .evt        (evt_if.master),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [CNT_W-1:0] per);
    cfg_we     = 1'b1;
    cfg_ch     = ch;
    cfg_period = per;
    tick();
    cfg_we     = 1'b0;
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    cfg_we           = 1'b0;
    cfg_ch           = '0;
    cfg_period       = '0;
    ch_en            = '0;
    evt_if.evt_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    do_reset();

    // Reset state
    check("rst_valid", evt_if.evt_valid, 0);
    check("rst_ch", evt_if.evt_ch, 0);
    check("rst_ovr", evt_if.evt_overrun, 0);
    check("rst_pending", pending, 0);

    // 1: ch0 period 2, always ready -> event every second cycle
    evt_if.evt_ready = 1'b1;
    ch_en = 4'b0001;
    cfg(2'd0, 8'd2);
    tick(); tick();
    check("t1_pend_first", pending, 4'b0001);
    check("t1_valid_first_lo", evt_if.evt_valid, 0);
    tick();
    check("t1_valid_first", evt_if.evt_valid, 1);
    check("t1_ch_first", evt_if.evt_ch, 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("t1_valid", evt_if.evt_valid, k % 2);
      if (k % 2 == 1) begin
        check("t1_ch", evt_if.evt_ch, 0);
        check("t1_ovr", evt_if.evt_overrun, 0);
      end
    end

    // 2: four channels period 4 -> back-to-back 0,1,2,3 repeating
    do_reset();
    evt_if.evt_ready = 1'b1;
    for (int c = 0; c < 4; c++) cfg(2'(c), 8'd4);
    ch_en = 4'b1111;
    tick(); tick(); tick(); tick();
    check("t2_pend_all", pending, 4'b1111);
    check("t2_valid_lo", evt_if.evt_valid, 0);
    for (int k = 0; k < 12; k++) begin
      tick();
      check("t2_valid", evt_if.evt_valid, 1);
      check("t2_ch", evt_if.evt_ch, k % 4);
      check("t2_ovr", evt_if.evt_overrun, 0);
    end

    // 3: ch1 period 3 held unaccepted -> stable event, later overrun flagged
    do_reset();
    ch_en = 4'b0010;
    cfg(2'd1, 8'd3);
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 3) begin
        check("t3_pend_first", pending, 4'b0010);
        check("t3_valid_lo", evt_if.evt_valid, 0);
      end
      if (k >= 4) begin
        check("t3_hold_valid", evt_if.evt_valid, 1);
        check("t3_hold_ch", evt_if.evt_ch, 1);
        check("t3_hold_ovr", evt_if.evt_overrun, 0);
      end
    end
    check("t3_pend_held", pending, 4'b0010);
    evt_if.evt_ready = 1'b1;
    tick();
    check("t3_ovr_valid", evt_if.evt_valid, 1);
    check("t3_ovr_ch", evt_if.evt_ch, 1);
    check("t3_ovr_set", evt_if.evt_overrun, 1);
    tick();
    check("t3_gap", evt_if.evt_valid, 0);
    tick();
    check("t3_next_valid", evt_if.evt_valid, 1);
    check("t3_next_ovr", evt_if.evt_overrun, 0);

    // 4: period 0 enabled, then valid period but disabled -> ch2 never fires
    do_reset();
    evt_if.evt_ready = 1'b1;
    ch_en = 4'b0100;
    cfg(2'd2, 8'd0);
    seen = 1'b0;
    for (int k = 0; k < 25; k++) begin
      tick();
      seen = seen | evt_if.evt_valid | pending[2];
    end
    check("t4_period0_quiet", seen, 0);
    ch_en = 4'b0000;
    cfg(2'd2, 8'd3);
    seen = 1'b0;
    for (int k = 0; k < 25; k++) begin
      tick();
      seen = seen | evt_if.evt_valid | pending[2];
    end
    check("t4_disabled_quiet", seen, 0);

    // 5: reconfigure ch0 in its wrap cycle -> wrap suppressed, next 5 cycles later
    do_reset();
    evt_if.evt_ready = 1'b1;
    ch_en = 4'b0001;
    cfg(2'd0, 8'd3);
    tick(); tick();
    check("t5_pre_pend", pending, 0);
    cfg(2'd0, 8'd5);
    check("t5_cfg_pend", pending, 0);
    check("t5_cfg_valid", evt_if.evt_valid, 0);
    tick();
    check("t5_no_evt", evt_if.evt_valid, 0);
    tick(); tick(); tick();
    check("t5_pend_early", pending, 0);
    tick();
    check("t5_pend_late", pending, 4'b0001);
    tick();
    check("t5_evt_valid", evt_if.evt_valid, 1);
    check("t5_evt_ch", evt_if.evt_ch, 0);

    // 6: async reset mid-handshake, then pointer back at channel 0
    do_reset();
    cfg(2'd1, 8'd4);
    cfg(2'd2, 8'd2);
    cfg(2'd3, 8'd4);
    ch_en = 4'b1110;
    tick(); tick();
    check("t6_pend_ch2", pending, 4'b0100);
    tick();
    check("t6_valid_ch2", evt_if.evt_valid, 1);
    check("t6_ch2", evt_if.evt_ch, 2);
    ch_en = 4'b1010;
    tick();
    check("t6_pend_1010", pending, 4'b1010);
    check("t6_still_valid", evt_if.evt_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_valid", evt_if.evt_valid, 0);
    check("t6_async_ch", evt_if.evt_ch, 0);
    check("t6_async_ovr", evt_if.evt_overrun, 0);
    check("t6_async_pend", pending, 0);
    ch_en = 4'b0000;
    tick();
    rst = 1'b0;
    evt_if.evt_ready = 1'b1;
    cfg(2'd0, 8'd4);
    cfg(2'd3, 8'd4);
    ch_en = 4'b1001;
    tick(); tick(); tick(); tick();
    check("t6_pend_1001", pending, 4'b1001);
    tick();
    check("t6_prio_valid", evt_if.evt_valid, 1);
    check("t6_prio_ch0", evt_if.evt_ch, 0);
    tick();
    check("t6_then_ch3", evt_if.evt_ch, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
